memory_access_stage: RTL

Pipeline MEM stage plus MEM/WB register, sitting between execute and write-back. Takes the EX/MEM payload, performs loads and stores on a data memory through a req/ack handshake, stalls upstream while an access is outstanding, aligns and sign-extends load data, and registers `mem_data_out`, `ALU_result_mem` and `control_word_mem` for the write-back stage.

---
 rtl/mem_pkg.sv | 53 +++++
 rtl/load_store_align.sv | 53 +++++
 rtl/memory_access_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: RV32I load/store funct3 codes,
// FSM states and the layout of the EX/MEM and MEM/WB control words.
package mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam int CW_EX_W      = 14;
   localparam int CW_WB_W      = 9;
   localparam int CW_MEM_READ  = 13;
   localparam int CW_MEM_WRITE = 12;
   localparam int CW_F3_LSB    = 9;
   localparam int CW_F3_W      = 3;
   localparam int WB_RF_WB     = 8;

   typedef enum logic {
      IDLE,
      BUSY
   } memState_e;

   typedef enum logic [1:0] {
      SIZE_B,
      SIZE_H,
      SIZE_W
   } accSize_e;

   // Unrecognised funct3 codes fall back to a full-word access.
   function automatic accSize_e accessSize(input logic isStore, input logic [2:0] funct3);
      accSize_e size;
      size = SIZE_W;
      if (isStore) begin
         case (funct3)
            F3_SB:   size = SIZE_B;
            F3_SH:   size = SIZE_H;
            default: size = SIZE_W;
         endcase
      end else begin
         case (funct3)
            F3_LB, F3_LBU: size = SIZE_B;
            F3_LH, F3_LHU: size = SIZE_H;
            default:       size = SIZE_W;
         endcase
      end
      return size;
   endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane logic: store strobes and lane replication,
// misalignment detection, and load extraction with sign/zero extension.
module load_store_align
   import mem_pkg::*;
(
   input  logic        isStore_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] storeData_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic        misaligned_o,
   input  logic [2:0]  loadFunct3_i,
   input  logic [1:0]  loadOffset_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] loadData_o
);

   accSize_e    size;
   logic [31:0] shifted;

   always_comb begin
      size         = accessSize(isStore_i, funct3_i);
      wstrb_o      = 4'b1111;
      wdata_o      = storeData_i;
      misaligned_o = 1'b0;
      case (size)
         SIZE_B: begin
            wstrb_o = 4'b0001 << offset_i;
            wdata_o = {4{storeData_i[7:0]}};
         end
         SIZE_H: begin
            wstrb_o      = 4'b0011 << offset_i;
            wdata_o      = {2{storeData_i[15:0]}};
            misaligned_o = offset_i[0];
         end
         default: misaligned_o = (offset_i != 2'b00);
      endcase
   end

   // The addressed byte/halfword is brought down to bit 0 before extension.
   always_comb begin
      shifted = rdata_i >> {loadOffset_i, 3'b000};
      case (loadFunct3_i)
         F3_LB:   loadData_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_LBU:  loadData_o = {24'b0, shifted[7:0]};
         F3_LH:   loadData_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_LHU:  loadData_o = {16'b0, shifted[15:0]};
         default: loadData_o = shifted;
      endcase
   end

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage and MEM/WB register: drives the data-memory handshake, stalls
// upstream while an access is outstanding and registers write-back payload.
module memory_access_stage
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_ex,
   input  logic [31:0]       ALU_result_ex,
   input  logic [31:0]       rs2_data_ex,
   input  logic [13:0]       control_word_ex,
   output logic              stall_o,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_wstrb,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic              misaligned_o,
   output logic [31:0]       mem_data_out,
   output logic [31:0]       ALU_result_mem,
   output logic [8:0]        control_word_mem
);

   memState_e         state_q;
   logic              req_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic [2:0]        funct3_q;
   logic [1:0]        offset_q;
   logic              misaligned_q;
   logic [31:0]       memData_q;
   logic [31:0]       aluResult_q;
   logic [8:0]        ctrlWb_q;

   logic              memRead;
   logic              memWrite;
   logic [2:0]        funct3;
   logic [8:0]        wbWord;
   logic [1:0]        offset;
   logic              memOp;
   logic              accessOk;
   logic [3:0]        alignStrb;
   logic [31:0]       alignWdata;
   logic              alignMisaligned;
   logic [31:0]       loadData;

   assign memRead  = control_word_ex[CW_MEM_READ];
   assign memWrite = control_word_ex[CW_MEM_WRITE];
   assign funct3   = control_word_ex[CW_F3_LSB +: CW_F3_W];
   assign wbWord   = control_word_ex[CW_WB_W-1:0];
   assign offset   = ALU_result_ex[1:0];
   assign memOp    = valid_ex & (memRead | memWrite);
   assign accessOk = memOp & ~alignMisaligned;

   load_store_align uAlign (
      .isStore_i    (memWrite),
      .funct3_i     (funct3),
      .offset_i     (offset),
      .storeData_i  (rs2_data_ex),
      .wstrb_o      (alignStrb),
      .wdata_o      (alignWdata),
      .misaligned_o (alignMisaligned),
      .loadFunct3_i (funct3_q),
      .loadOffset_i (offset_q),
      .rdata_i      (dmem_rdata),
      .loadData_o   (loadData)
   );

   // Reset gates the stall so the upstream never sees it while reset is held.
   assign stall_o = ~rst & ((state_q == IDLE) ? accessOk : ~dmem_ack);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         funct3_q     <= '0;
         offset_q     <= '0;
         misaligned_q <= 1'b0;
         memData_q    <= '0;
         aluResult_q  <= '0;
         ctrlWb_q     <= '0;
      end else begin
         misaligned_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accessOk) begin
                  state_q     <= BUSY;
                  req_q       <= 1'b1;
                  we_q        <= memWrite;
                  addr_q      <= {ALU_result_ex[ADDR_W-1:2], 2'b00};
                  wdata_q     <= alignWdata;
                  wstrb_q     <= memWrite ? alignStrb : 4'b0000;
                  funct3_q    <= funct3;
                  offset_q    <= offset;
                  memData_q   <= '0;
                  aluResult_q <= '0;
                  ctrlWb_q    <= '0;
               end else begin
                  // A memory op reaching here was misaligned and is dropped.
                  misaligned_q <= memOp;
                  memData_q    <= '0;
                  aluResult_q  <= ALU_result_ex;
                  ctrlWb_q     <= {wbWord[WB_RF_WB] & valid_ex & ~memOp, wbWord[WB_RF_WB-1:0]};
               end
            end
            BUSY: begin
               if (dmem_ack) begin
                  state_q     <= IDLE;
                  req_q       <= 1'b0;
                  memData_q   <= we_q ? 32'h0 : loadData;
                  aluResult_q <= ALU_result_ex;
                  ctrlWb_q    <= wbWord;
               end else begin
                  memData_q   <= '0;
                  aluResult_q <= '0;
                  ctrlWb_q    <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dmem_req         = req_q;
   assign dmem_we          = we_q;
   assign dmem_addr        = addr_q;
   assign dmem_wdata       = wdata_q;
   assign dmem_wstrb       = wstrb_q;
   assign misaligned_o     = misaligned_q;
   assign mem_data_out     = memData_q;
   assign ALU_result_mem   = aluResult_q;
   assign control_word_mem = ctrlWb_q;

endmodule
